// File: rtl/uart_sha256_host.sv
// Host-side initiator for the UART SHA-256 protocol: frames a message as 0x01, payload, 0xFF
// and decodes the 64-character hex reply into a 256-bit digest. Includes its own 8N1 UART cores.

module uart_tx_core #(
    parameter int BAUD_DIV = 174
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx
);
    localparam int CW = $clog2(BAUD_DIV + 1);

    logic [CW-1:0] baud_cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic [8:0]    shift_reg;
    logic          busy_reg;
    logic          tx_reg;

    // bit_cnt 0 is the start bit, 1..8 data LSB first, 9 the stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '1;
            busy_reg     <= 1'b0;
            tx_reg       <= 1'b1;
        end else if (!busy_reg) begin
            if (tx_start) begin
                busy_reg     <= 1'b1;
                tx_reg       <= 1'b0;
                shift_reg    <= {1'b1, tx_data};
                bit_cnt_reg  <= '0;
                baud_cnt_reg <= '0;
            end
        end else if (baud_cnt_reg == CW'(BAUD_DIV - 1)) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == 4'd9) begin
                busy_reg <= 1'b0;
                tx_reg   <= 1'b1;
            end else begin
                tx_reg      <= shift_reg[0];
                shift_reg   <= {1'b1, shift_reg[8:1]};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
        end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
        end
    end

    assign tx_busy = busy_reg;
    assign tx      = tx_reg;
endmodule

module uart_rx_core #(
    parameter int BAUD_DIV = 174
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid
);
    localparam int CW = $clog2(BAUD_DIV + 1);

    logic [1:0]    sync_reg;
    logic          active_reg;
    logic [CW-1:0] baud_cnt_reg;
    logic [3:0]    bit_idx_reg;
    logic [7:0]    data_reg;
    logic          valid_reg;
    logic          rx_s;

    assign rx_s = sync_reg[1];

    // Start bit is re-checked at its midpoint, so every later sample lands mid-bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg     <= 2'b11;
            active_reg   <= 1'b0;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], rx};
            valid_reg <= 1'b0;
            if (!active_reg) begin
                if (!rx_s) begin
                    active_reg   <= 1'b1;
                    baud_cnt_reg <= '0;
                    bit_idx_reg  <= '0;
                end
            end else if (bit_idx_reg == 4'd0) begin
                if (baud_cnt_reg == CW'(BAUD_DIV / 2 - 1)) begin
                    baud_cnt_reg <= '0;
                    if (rx_s) active_reg  <= 1'b0;
                    else      bit_idx_reg <= 4'd1;
                end else begin
                    baud_cnt_reg <= baud_cnt_reg + CW'(1);
                end
            end else if (baud_cnt_reg == CW'(BAUD_DIV - 1)) begin
                baud_cnt_reg <= '0;
                if (bit_idx_reg == 4'd9) begin
                    active_reg <= 1'b0;
                    valid_reg  <= rx_s;
                end else begin
                    data_reg    <= {rx_s, data_reg[7:1]};
                    bit_idx_reg <= bit_idx_reg + 4'd1;
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + CW'(1);
            end
        end
    end

    assign rx_data  = data_reg;
    assign rx_valid = valid_reg;
endmodule

module uart_sha256_host #(
    parameter int CLK_FREQ       = 20_000_000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic         clk,
    input  logic         rst,
    output logic         uart_tx,
    input  logic         uart_rx,
    input  logic [7:0]   msg_data,
    input  logic         msg_valid,
    input  logic         msg_last,
    output logic         msg_ready,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         err,
    output logic [1:0]   err_code
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SEND_START, SEND_DATA, SEND_TERM, RECV, FINISH} state_t;

    state_t         state_reg, state_next;
    logic           pending_reg, term_sent_reg, bad_ff_reg;
    logic [6:0]     nib_cnt_reg;
    logic [TW-1:0]  tout_reg;
    logic [255:0]   shreg_reg, digest_reg;
    logic           busy_reg, dv_reg, err_reg;
    logic [1:0]     err_code_reg;

    logic           tx_start, tx_busy, consume, can_issue;
    logic [7:0]     tx_data, rx_data;
    logic           rx_valid, is_hex;
    logic [3:0]     nib;

    uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx(uart_tx)
    );

    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk(clk), .rst(rst), .rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    // pending covers the cycle between tx_start and tx_busy rising
    assign can_issue = !tx_busy && !pending_reg;

    // Letters share low nibble 1..6 in both cases, so +9 gives 10..15
    always_comb begin
        is_hex = 1'b1;
        nib    = rx_data[3:0];
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            nib = rx_data[3:0];
        end else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
                     (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
            nib = rx_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        consume    = 1'b0;
        case (state_reg)
            IDLE: if (msg_valid) state_next = SEND_START;
            SEND_START: if (can_issue) begin
                tx_start   = 1'b1;
                tx_data    = 8'h01;
                state_next = SEND_DATA;
            end
            SEND_DATA: if (msg_valid && can_issue) begin
                consume = 1'b1;
                if (msg_data != 8'hFF) begin
                    tx_start = 1'b1;
                    tx_data  = msg_data;
                end
                if (msg_last) state_next = SEND_TERM;
            end
            SEND_TERM: begin
                if (!term_sent_reg) begin
                    if (can_issue) begin
                        tx_start = 1'b1;
                        tx_data  = 8'hFF;
                    end
                end else if (can_issue) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    if (!is_hex || nib_cnt_reg == 7'd63) state_next = FINISH;
                end else if (tout_reg == TW'(TIMEOUT_CYCLES)) begin
                    state_next = FINISH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pending_reg   <= 1'b0;
            term_sent_reg <= 1'b0;
            bad_ff_reg    <= 1'b0;
            nib_cnt_reg   <= '0;
            tout_reg      <= '0;
            shreg_reg     <= '0;
            digest_reg    <= '0;
            busy_reg      <= 1'b0;
            dv_reg        <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            dv_reg    <= 1'b0;
            err_reg   <= 1'b0;
            if (tx_start)     pending_reg <= 1'b1;
            else if (tx_busy) pending_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    term_sent_reg <= 1'b0;
                    if (msg_valid) begin
                        busy_reg     <= 1'b1;
                        err_code_reg <= 2'b00;
                        bad_ff_reg   <= 1'b0;
                    end
                end
                SEND_DATA: if (consume && msg_data == 8'hFF) bad_ff_reg <= 1'b1;
                SEND_TERM: begin
                    if (tx_start) term_sent_reg <= 1'b1;
                    if (state_next == RECV) begin
                        nib_cnt_reg <= '0;
                        shreg_reg   <= '0;
                        tout_reg    <= '0;
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        if (is_hex) begin
                            shreg_reg   <= {shreg_reg[251:0], nib};
                            nib_cnt_reg <= nib_cnt_reg + 7'd1;
                            tout_reg    <= '0;
                            if (nib_cnt_reg == 7'd63) digest_reg <= {shreg_reg[251:0], nib};
                        end else begin
                            err_code_reg <= 2'b01;
                        end
                    end else if (tout_reg == TW'(TIMEOUT_CYCLES)) begin
                        err_code_reg <= 2'b10;
                    end else begin
                        tout_reg <= tout_reg + TW'(1);
                    end
                end
                FINISH: begin
                    busy_reg <= 1'b0;
                    if (err_code_reg != 2'b00) begin
                        err_reg <= 1'b1;
                    end else if (bad_ff_reg) begin
                        err_reg      <= 1'b1;
                        err_code_reg <= 2'b11;
                    end else begin
                        dv_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign msg_ready    = consume;
    assign busy         = busy_reg;
    assign digest       = digest_reg;
    assign digest_valid = dv_reg;
    assign err          = err_reg;
    assign err_code     = err_code_reg;
endmodule

// File: tb/tb_uart_sha256_host.sv
// Bench for uart_sha256_host: a serial device model answers each frame with a scripted hex reply,
// and a job-level model predicts wire bytes, handshake count, outcome and digest.

module tb_uart_sha256_host;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int TOUT     = 5000;
    localparam int BD       = CLK_FREQ / BAUD;
    localparam string ABC_S = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
    localparam logic [255:0] ABC_D =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         uart_tx;
    logic         uart_rx = 1'b1;
    logic [7:0]   msg_data = 8'h00;
    logic         msg_valid = 1'b0;
    logic         msg_last = 1'b0;
    logic         msg_ready, busy, digest_valid, err;
    logic [255:0] digest;
    logic [1:0]   err_code;

    uart_sha256_host #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst), .uart_tx(uart_tx), .uart_rx(uart_rx),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
        .busy(busy), .digest(digest), .digest_valid(digest_valid), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    logic [7:0]   tx_seen[$], reply_q[$], pl_q[$], exp_wire_q[$];
    bit           reply_req = 0, dev_busy = 0;
    int           dev_sent = 0, dev_last_end = 0;
    int           n_ready = 0, n_dv = 0, n_err = 0, err_cyc = 0;
    logic         exp_ok = 1'b0;
    logic [1:0]   exp_code = 2'b00;
    logic [255:0] exp_digest = '0, dg_model = '0;
    logic [7:0]   mon_b;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {uart_tx, busy, msg_ready, digest_valid, err, err_code}, 7'b1000000);
        check({tag, "_digest"}, digest, 256'd0);
    endtask

    // Line monitor on uart_tx: collect framed bytes, request a reply after the terminator
    initial forever begin
        @(negedge clk);
        if (!rst && uart_tx === 1'b0) begin
            repeat (BD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(negedge clk);
                mon_b[i] = uart_tx;
            end
            repeat (BD) @(negedge clk);
            tx_seen.push_back(mon_b);
            if (mon_b == 8'hFF) begin
                repeat (BD) @(negedge clk);
                reply_req = 1;
            end
        end
    end

    // Device model: sends the queued reply characters back to back, 8N1
    initial forever begin
        wait (reply_req);
        reply_req = 0;
        dev_busy  = 1;
        @(posedge clk); #1;
        while (reply_q.size() > 0) begin
            logic [9:0] frame;
            frame = {1'b1, reply_q.pop_front(), 1'b0};
            for (int k = 0; k < 10; k++) begin
                uart_rx = frame[k];
                repeat (BD) @(posedge clk);
                #1;
            end
            dev_sent++;
        end
        dev_last_end = cyc;
        dev_busy = 0;
    end

    // Per-cycle compare against the job expectations
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (msg_ready) begin
                n_ready++;
                check("ready_while_busy", busy, 1'b1);
            end
            if (digest_valid) begin
                n_dv++;
                check("outcome_at_dv", {digest_valid, err}, exp_ok ? 2'b10 : 2'b01);
                check("digest_at_dv", digest, exp_digest);
                check("busy_at_dv", busy, 1'b0);
            end
            if (err) begin
                n_err++;
                err_cyc = cyc;
                check("outcome_at_err", {digest_valid, err}, exp_ok ? 2'b10 : 2'b01);
                check("err_code_at_err", err_code, exp_code);
                check("busy_at_err", busy, 1'b0);
            end
        end
    end

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    function automatic string mixcase(input string s);
        string r;
        logic [7:0] c;
        r = s;
        for (int i = 0; i < r.len(); i++) begin
            c = r.getc(i);
            if (c >= 8'h61 && c <= 8'h66 && $urandom_range(0, 1) == 1) r.putc(i, c - 8'h20);
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic build_exp_wire();
        logic has_ff;
        has_ff = 1'b0;
        exp_wire_q.delete();
        exp_wire_q.push_back(8'h01);
        foreach (pl_q[i]) begin
            if (pl_q[i] == 8'hFF) has_ff = 1'b1;
            else exp_wire_q.push_back(pl_q[i]);
        end
        exp_wire_q.push_back(8'hFF);
        return has_ff;
    endfunction

    task automatic check_wire(input string name);
        check({name, "_wire_len"}, tx_seen.size(), exp_wire_q.size());
        for (int i = 0; i < tx_seen.size() && i < exp_wire_q.size(); i++)
            check($sformatf("%s_wire%0d", name, i), tx_seen[i], exp_wire_q[i]);
    endtask

    task automatic build_reply(input string rs, input int rlen, input int bad);
        reply_q.delete();
        for (int i = 0; i < rlen; i++) reply_q.push_back((i == bad) ? 8'h67 : rs.getc(i));
    endtask

    task automatic send_msg(input int stall_at);
        int t;
        for (int i = 0; i < pl_q.size(); i++) begin
            msg_data  = pl_q[i];
            msg_last  = (i == pl_q.size() - 1);
            msg_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!msg_ready && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (!msg_ready) check("msg_ready_wait", msg_ready, 1'b1);
            @(posedge clk); #1;
            if (i == stall_at) begin
                msg_valid = 1'b0;
                repeat (1000) @(posedge clk);
                #1;
            end
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic wait_device_idle(input string name);
        int t = 0;
        while (dev_busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_device_idle"}, dev_busy, 1'b0);
    endtask

    task automatic run_job(input string name, input string rs, input int rlen, input int bad,
                           input logic [255:0] rv);
        logic has_ff;
        logic [1:0] code;
        int t;
        has_ff = build_exp_wire();
        if (bad >= 0 && bad < rlen) code = 2'b01;
        else if (rlen < 64)         code = 2'b10;
        else if (has_ff)            code = 2'b11;
        else                        code = 2'b00;
        exp_ok   = (code == 2'b00);
        exp_code = code;
        if (code == 2'b00 || code == 2'b11) dg_model = rv;
        exp_digest = dg_model;
        build_reply(rs, rlen, bad);
        tx_seen.delete();
        n_ready = 0; n_dv = 0; n_err = 0;
        send_msg(-1);
        t = 0;
        while (n_dv + n_err == 0 && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_completed"}, (n_dv + n_err) != 0, 1'b1);
        repeat (4) @(negedge clk);
        wait_device_idle(name);
        check_wire(name);
        check({name, "_ready_pulses"}, n_ready, pl_q.size());
        check({name, "_dv_pulses"}, n_dv, exp_ok ? 1 : 0);
        check({name, "_err_pulses"}, n_err, exp_ok ? 0 : 1);
        check({name, "_err_code"}, err_code, code);
        check({name, "_digest"}, digest, dg_model);
        check({name, "_busy_after"}, busy, 1'b0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] v;
        string        s;
        int           base, t, delta;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        pl_q = '{8'h61, 8'h62, 8'h63};
        run_job("abc_lower", ABC_S, 64, -1, ABC_D);
        check("abc_literal_digest", digest, ABC_D);

        s = ABC_S;
        run_job("abc_upper", s.toupper(), 64, -1, ABC_D);

        run_job("bad_hex", ABC_S, 15, 9, ABC_D);

        run_job("abc_after_err", ABC_S, 64, -1, ABC_D);

        run_job("timeout", ABC_S, 20, -1, ABC_D);
        delta = err_cyc - dev_last_end;
        checks++;
        if (delta < TOUT - BD || delta > TOUT + BD) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles after last char, expected about %0d", delta, TOUT);
        end

        v = rand256();
        pl_q = '{8'h41, 8'hFF, 8'h42};
        run_job("ff_payload", $sformatf("%064h", v), 64, -1, v);

        // Stall mid-message, then reset while receiving the reply
        pl_q.delete();
        for (int i = 0; i < 4; i++) pl_q.push_back(8'($urandom_range(0, 254)));
        void'(build_exp_wire());
        v = rand256();
        build_reply($sformatf("%064h", v), 10, -1);
        exp_ok = 1'b0; exp_code = 2'b00;
        tx_seen.delete();
        n_ready = 0; n_dv = 0; n_err = 0;
        base = dev_sent;
        send_msg(1);
        t = 0;
        while (tx_seen.size() < 6 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_wire("stall");
        check("stall_ready_pulses", n_ready, 4);
        t = 0;
        while (dev_sent < base + 5 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("stall_reply_started", dev_sent >= base + 5, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_recv");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_released");
        check("rst_no_pulses", n_dv + n_err, 0);
        dg_model = '0;
        wait_device_idle("rst");
        repeat (20) @(posedge clk);
        #1;

        pl_q.delete();
        t = $urandom_range(3, 6);
        for (int i = 0; i < t; i++) pl_q.push_back(8'($urandom_range(0, 254)));
        v = rand256();
        run_job("random", mixcase($sformatf("%064h", v)), 64, -1, v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
